// File: rtl/cpu_run_monitor.sv
// Run controller and monitor for the single-cycle CPU: sequences CPU reset,
// logs every change on the CPU out bus and ends the run on halt or timeout.
module cpu_run_monitor #(
  parameter int DATA_W        = 32,
  parameter int RST_CYCLES    = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_CYCLES    = 1024,
  parameter int TRACE_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               cont_in,
  input  logic [DATA_W-1:0]                  expected,
  input  logic [DATA_W-1:0]                  cpu_out,
  output logic                               cpu_reset,
  output logic                               cpu_cont,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic                               overflow,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    cycle_count,
  output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0]     rd_addr,
  output logic [DATA_W-1:0]                  rd_data
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int TW = $clog2(TRACE_DEPTH + 1);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CYCLES);
  localparam logic [TW-1:0] DEPTH_C  = TW'(TRACE_DEPTH);
  localparam logic [SW-1:0] STABLE_C = SW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET_CPU = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e              state_r;
  logic [RW-1:0]       rst_cnt_r;
  logic [SW-1:0]       stable_cnt_r;
  logic [DATA_W-1:0]   prev_r;
  logic                first_r;
  logic                cpu_reset_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;
  logic                timeout_r;
  logic                overflow_r;
  logic [CW-1:0]       cycle_count_r;
  logic [TW-1:0]       trace_count_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic [DATA_W-1:0]   trace_mem_r [TRACE_DEPTH];

  logic                log_s;
  logic                halt_s;
  logic                limit_s;
  logic                wr_en_s;
  logic [SW-1:0]       stable_next_s;
  logic [CW-1:0]       cycle_next_s;

  // Per-sample decisions for the RUN state: change logging, halt and timeout
  always_comb begin
    log_s         = 1'b0;
    halt_s        = 1'b0;
    stable_next_s = stable_cnt_r;
    cycle_next_s  = cycle_count_r + CW'(1);
    limit_s       = (cycle_next_s == MAX_C);
    if (first_r) begin
      log_s         = 1'b1;
      stable_next_s = {SW{1'b0}};
    end else if (cpu_out != prev_r) begin
      log_s         = 1'b1;
      stable_next_s = {SW{1'b0}};
    end else begin
      stable_next_s = stable_cnt_r + SW'(1);
      halt_s        = (stable_next_s == STABLE_C);
    end
    if ((state_r == RUN) && log_s && (trace_count_r != DEPTH_C)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Run sequencing FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rst_cnt_r     <= {RW{1'b0}};
      stable_cnt_r  <= {SW{1'b0}};
      prev_r        <= {DATA_W{1'b0}};
      first_r       <= 1'b0;
      cpu_reset_r   <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      timeout_r     <= 1'b0;
      overflow_r    <= 1'b0;
      cycle_count_r <= {CW{1'b0}};
      trace_count_r <= {TW{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r       <= RESET_CPU;
            rst_cnt_r     <= {RW{1'b0}};
            stable_cnt_r  <= {SW{1'b0}};
            cpu_reset_r   <= 1'b1;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            overflow_r    <= 1'b0;
            cycle_count_r <= {CW{1'b0}};
            trace_count_r <= {TW{1'b0}};
          end
        end
        RESET_CPU: begin
          if (rst_cnt_r == RST_LAST) begin
            state_r     <= RUN;
            cpu_reset_r <= 1'b0;
            first_r     <= 1'b1;
          end else begin
            rst_cnt_r <= rst_cnt_r + RW'(1);
          end
        end
        RUN: begin
          cycle_count_r <= cycle_next_s;
          stable_cnt_r  <= stable_next_s;
          prev_r        <= cpu_out;
          first_r       <= 1'b0;
          if (log_s) begin
            if (trace_count_r == DEPTH_C) begin
              overflow_r <= 1'b1;
            end else begin
              trace_count_r <= trace_count_r + TW'(1);
            end
          end
          // A halt on the final allowed cycle still counts as a halt
          if (halt_s) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= (cpu_out == expected);
            timeout_r <= 1'b0;
          end else if (limit_s) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= 1'b0;
            timeout_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cpu_reset_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Trace RAM: never cleared, read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      trace_mem_r[trace_count_r[AW-1:0]] <= cpu_out;
    end
    rd_data_r <= trace_mem_r[rd_addr];
  end

  assign cpu_cont    = (state_r == RUN) && cont_in;
  assign cpu_reset   = cpu_reset_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign overflow    = overflow_r;
  assign cycle_count = cycle_count_r;
  assign trace_count = trace_count_r;
  assign rd_data     = rd_data_r;

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and monitor for the single-cycle CPU. It drives the CPU's reset and continue inputs and samples the CPU's `out` bus every cycle. It logs each distinct `out` value into a trace buffer and ends the run on halt (output stable) or timeout. It replaces the free-running simulation harness with a parametrised on-chip block that reports pass/fail against an expected result and supports trace readback.

## Interface
Parameters:
- `DATA_W`, 32: width of CPU `out` bus and trace entries
- `RST_CYCLES`, 2: cycles `cpu_reset` is held high at run start (≥1)
- `STABLE_CYCLES`, 8: consecutive unchanged samples that declare halt (≥1)
- `MAX_CYCLES`, 1024: RUN-cycle limit before timeout
- `TRACE_DEPTH`, 16: trace buffer entries (power of 2)

Ports:
- `clk` in 1: clock; all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `start` in 1: begin a run; honoured only in IDLE or DONE
- `cont_in` in 1: continue request, forwarded to CPU during RUN only
- `expected` in DATA_W: expected final `out` value, sampled at halt
- `cpu_out` in DATA_W: CPU `out` bus
- `cpu_reset` out 1: CPU reset drive
- `cpu_cont` out 1: CPU continue drive
- `busy` out 1: high in RESET_CPU and RUN
- `done` out 1: high in DONE
- `pass` out 1: valid when `done`
- `timeout` out 1: valid when `done`
- `overflow` out 1: trace lost at least one change
- `cycle_count` out $clog2(MAX_CYCLES+1): RUN cycles elapsed
- `trace_count` out $clog2(TRACE_DEPTH+1): entries written
- `rd_addr` in $clog2(TRACE_DEPTH): trace read address
- `rd_data` out DATA_W: trace entry at `rd_addr`, registered

## Operation
- States: IDLE, RESET_CPU, RUN, DONE.
- IDLE:
  - `cpu_reset`=1 and `cpu_cont`=0.
  - `start` moves the block to RESET_CPU.
  - Entry into RESET_CPU clears `done`, `pass`, `timeout`, `overflow`, `cycle_count`, `trace_count`, and the stable counter.
- RESET_CPU:
  - `cpu_reset`=1 for exactly RST_CYCLES cycles, then the block moves to RUN.
- RUN:
  - `cpu_reset`=0 and `cpu_cont`=`cont_in`, combinational pass-through gated by state.
  - `cycle_count` increments every RUN cycle.
  - The first RUN sample is always logged.
  - On each later sample, if `cpu_out` ≠ the previous sample, the sample is logged and the stable counter resets to 0. Otherwise the stable counter increments.
  - Logging writes `cpu_out` at index `trace_count`, then increments `trace_count`.
  - When `trace_count`==TRACE_DEPTH, the write is dropped and `overflow` is set (sticky until next start).
- Halt: the stable counter reaches STABLE_CYCLES, meaning STABLE_CYCLES consecutive samples equal their predecessor. Then:
  - move to DONE;
  - `pass` = (`cpu_out` == `expected`) at that cycle;
  - `timeout`=0.
- Timeout: `cycle_count` reaches MAX_CYCLES without halt. Then:
  - move to DONE;
  - `timeout`=1, `pass`=0.
- Halt and timeout in the same cycle: halt wins, `timeout`=0.
- DONE:
  - `cpu_reset`=0 and `cpu_cont`=0, so the CPU state stays observable.
  - Results hold until `start`, which behaves as in IDLE.
- `start` while `busy` is ignored.
- Trace reads are allowed in any state. Addresses ≥ `trace_count` return stale contents; they are not an error.

## Timing
- Reset values:
  - state IDLE;
  - `cpu_reset`=1, `cpu_cont`=0;
  - `busy`=`done`=`pass`=`timeout`=`overflow`=0;
  - `cycle_count`=0, `trace_count`=0.
  - Trace RAM is not cleared.
- `reset` mid-run aborts immediately: the next edge yields the reset values, and `cpu_reset` goes high in the same cycle the reset is registered.
- `start` registered at edge N:
  - `busy`=1 and `cpu_reset`=1 from N+1;
  - RUN begins at edge N+1+RST_CYCLES.
- Minimum run length: halt occurs no earlier than STABLE_CYCLES+1 RUN cycles after RUN entry.
- `done` rises on the edge after the halt or timeout condition is detected. `pass` and `timeout` are valid in the same cycle as `done`.
- `rd_data` has 1-cycle latency from `rd_addr`.
- A trace write and a read at the same address in the same cycle return the old data.

## Test plan
- Reset then idle:
  - `cpu_reset`=1, all status 0.
  - `start` with DATA_W=32, RST_CYCLES=2 → `cpu_reset` high exactly 2 cycles after `busy` rises.
- Halt pass, STABLE_CYCLES=8, `expected`=55:
  - stimulus: `cpu_out` sequence 0,1,1,2,3,5,8,13,21,34,55, then held.
  - → `done`=1, `pass`=1, `timeout`=0, `trace_count`=10.
  - → trace reads return 0,1,2,3,5,8,13,21,34,55.
- Halt fail: same sequence with `expected`=89 → `done`=1, `pass`=0, `timeout`=0.
- Timeout, MAX_CYCLES=64:
  - stimulus: `cpu_out` toggles 0/1 every cycle.
  - → `done` after 64 RUN cycles, `timeout`=1, `pass`=0, `cycle_count`=64.
  - → `overflow`=1 with TRACE_DEPTH=16 and `trace_count`=16.
- Corner cases:
  - Halt on the cycle `cycle_count` reaches MAX_CYCLES → `timeout`=0 and `pass` per compare.
  - `start` pulsed during RUN → ignored.
  - `cont_in`=1 in DONE → `cpu_cont`=0.
- Abort: `reset` asserted mid-RUN → next cycle returns all reset values. A following `start` runs cleanly with `trace_count` restarting at 0.
